// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encoding, halt word, field positions.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package instruction_fetch_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_HALT  = 2'd2,
    ST_FAULT = 2'd3
  } ifu_state_t;

  // An all-ones word is never a legal MIPS encoding we execute; it stops the sequencer.
  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int FUNCT_MSB  = 5;
  localparam int FUNCT_LSB  = 0;

  // Branch displacement: sign-extended 16-bit word offset turned into a byte offset.
  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_instr_mem.sv
// Word-addressed instruction store: one synchronous write port, one asynchronous read port.
// Latency: read is combinational; a write is visible on the read port the cycle after its edge.
// Backpressure: none; the write port accepts every cycle we is high.
//
// Ports: clk, we/waddr/wdata (load port), raddr/rdata (fetch port).
module instruction_fetch_unit_instr_mem #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  // No reset: program contents must survive a reset of the fetch unit.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/instruction_fetch_unit.sv
// Program counter, instruction memory and run/halt/fault sequencer for the single-cycle MIPS datapath.
// Latency: instr/valid are combinational from pc; next PC and retired count take effect one edge later.
// Backpressure: stall holds pc and retired for the cycle; imem loads are dropped while running.
//
// Ports:
//   clk, reset                 clock and synchronous active-high reset
//   start, stall               sequencing controls
//   beq, alu_zero, j           same-cycle decode/ALU feedback selecting the next PC
//   imem_we/addr/wdata         program load port (IDLE, HALT, FAULT only)
//   instr, opcode, function_code, pc, pc_plus4, valid   fetch outputs to control unit
//   halted, fault, retired     status for the bench
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter int          MEM_DEPTH = 256,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         stall,
  input  logic                         beq,
  input  logic                         alu_zero,
  input  logic                         j,
  input  logic                         imem_we,
  input  logic [$clog2(MEM_DEPTH)-1:0] imem_addr,
  input  logic [31:0]                  imem_wdata,
  output logic [31:0]                  instr,
  output logic [5:0]                   opcode,
  output logic [5:0]                   function_code,
  output logic [31:0]                  pc,
  output logic [31:0]                  pc_plus4,
  output logic                         valid,
  output logic                         halted,
  output logic                         fault,
  output logic [31:0]                  retired
);

  localparam int AW = $clog2(MEM_DEPTH);
  // First byte address past the end of memory; computed at 33 bits so it cannot wrap.
  localparam logic [32:0] PC_LIMIT = 33'(MEM_DEPTH) * 33'd4;

  ifu_state_t  state;
  logic [31:0] next_pc;
  logic        next_pc_oob;
  logic        mem_we;
  logic        is_halt;
  logic        advance;

  // Loads are locked out while running so the executing program cannot be altered
  // under the fetch; reset also wins over a load on the same edge.
  assign mem_we = imem_we && (state != ST_RUN) && !reset;

  instruction_fetch_unit_instr_mem #(
    .DEPTH (MEM_DEPTH),
    .AW    (AW)
  ) u_instr_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (imem_addr),
    .wdata (imem_wdata),
    .raddr (pc[AW+1:2]),
    .rdata (instr)
  );

  assign opcode        = instr[OPCODE_MSB:OPCODE_LSB];
  assign function_code = instr[FUNCT_MSB:FUNCT_LSB];
  assign pc_plus4      = pc + 32'd4;

  assign is_halt = (instr == HALT_WORD);
  assign valid   = (state == ST_RUN) && !is_halt;
  assign halted  = (state == ST_HALT);
  assign fault   = (state == ST_FAULT);
  assign advance = valid && !stall;

  // Jump outranks branch; all arithmetic wraps modulo 2^32.
  always_comb begin
    next_pc = pc_plus4;
    if (j) begin
      next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
    end else if (beq && alu_zero) begin
      next_pc = pc_plus4 + branch_offset(instr[15:0]);
    end
  end

  assign next_pc_oob = ({1'b0, next_pc} >= PC_LIMIT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      pc      <= RESET_PC;
      retired <= 32'd0;
    end else begin
      case (state)
        ST_IDLE, ST_HALT: begin
          // HALT resumes at the held PC, i.e. on the halt word itself unless reloaded.
          if (start) begin
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (is_halt) begin
            state <= ST_HALT;
          end else if (advance) begin
            // The instruction executed even if its target is unreachable, so it still retires.
            retired <= retired + 32'd1;
            if (next_pc_oob) begin
              state <= ST_FAULT;
            end else begin
              pc <= next_pc;
            end
          end
        end
        ST_FAULT: begin
          state <= ST_FAULT;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, stall, beq, alu_zero, j;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic [31:0] instr, pc, pc_plus4, retired;
  logic [5:0]  opcode, function_code;
  logic        valid, halted, fault;

  int checks = 0;
  int errors = 0;

  instruction_fetch_unit #(
    .MEM_DEPTH (256),
    .RESET_PC  (32'h0000_0000)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .stall         (stall),
    .beq           (beq),
    .alu_zero      (alu_zero),
    .j             (j),
    .imem_we       (imem_we),
    .imem_addr     (imem_addr),
    .imem_wdata    (imem_wdata),
    .instr         (instr),
    .opcode        (opcode),
    .function_code (function_code),
    .pc            (pc),
    .pc_plus4      (pc_plus4),
    .valid         (valid),
    .halted        (halted),
    .fault         (fault),
    .retired       (retired)
  );

  always #5 clk = ~clk;

  // One record per cycle: inputs held for the cycle, outputs expected before its edge.
  typedef struct {
    logic        start;
    logic        stall;
    logic        beq;
    logic        zero;
    logic        j;
    logic [31:0] exp_pc;
    logic        exp_valid;
    logic        exp_halted;
    logic        exp_fault;
    logic [31:0] exp_retired;
  } step_t;

  localparam int NSTEPS = 21;
  step_t steps [NSTEPS];

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic load(input logic [7:0] addr, input logic [31:0] data);
    imem_we = 1'b1; imem_addr = addr; imem_wdata = data;
    @(posedge clk); #1;
    imem_we = 1'b0;
  endtask

  task automatic run_steps(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      start = steps[i].start; stall = steps[i].stall;
      beq = steps[i].beq; alu_zero = steps[i].zero; j = steps[i].j;
      @(negedge clk);
      chk("pc",      i, pc,              steps[i].exp_pc);
      chk("valid",   i, 32'(valid),      32'(steps[i].exp_valid));
      chk("halted",  i, 32'(halted),     32'(steps[i].exp_halted));
      chk("fault",   i, 32'(fault),      32'(steps[i].exp_fault));
      chk("retired", i, retired,         steps[i].exp_retired);
      @(posedge clk); #1;
    end
    start = 0; stall = 0; beq = 0; alu_zero = 0; j = 0;
  endtask

  initial begin
    //              start stall beq zero j   pc            vld hlt flt retired
    // straight-line program with halt at word 2
    steps[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00, 1'b0, 1'b0, 1'b0, 32'd0};
    steps[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00, 1'b1, 1'b0, 1'b0, 32'd0};
    steps[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h04, 1'b1, 1'b0, 1'b0, 32'd1};
    steps[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h08, 1'b0, 1'b0, 1'b0, 32'd2};
    steps[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h08, 1'b0, 1'b1, 1'b0, 32'd2};
    // resume from HALT at pc 8 (now beq -2): taken back to 4, then not taken to 12 (halt)
    steps[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h08, 1'b0, 1'b1, 1'b0, 32'd2};
    steps[6]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h08, 1'b1, 1'b0, 1'b0, 32'd2};
    steps[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h04, 1'b1, 1'b0, 1'b0, 32'd3};
    steps[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h08, 1'b1, 1'b0, 1'b0, 32'd4};
    steps[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0C, 1'b0, 1'b0, 1'b0, 32'd5};
    steps[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0C, 1'b0, 1'b1, 1'b0, 32'd5};
    // jumps: 0 -> 0x40, j+beq at 0x40 -> 0x10, 3-cycle stall, then jump to 0x400 faults
    steps[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h00, 1'b0, 1'b0, 1'b0, 32'd0};
    steps[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h00, 1'b1, 1'b0, 1'b0, 32'd0};
    steps[13] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h40, 1'b1, 1'b0, 1'b0, 32'd1};
    steps[14] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h10, 1'b1, 1'b0, 1'b0, 32'd2};
    steps[15] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h10, 1'b1, 1'b0, 1'b0, 32'd2};
    steps[16] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h10, 1'b1, 1'b0, 1'b0, 32'd2};
    steps[17] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h10, 1'b1, 1'b0, 1'b0, 32'd2};
    steps[18] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h14, 1'b1, 1'b0, 1'b0, 32'd3};
    steps[19] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h14, 1'b0, 1'b0, 1'b1, 32'd4};
    steps[20] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h14, 1'b0, 1'b0, 1'b1, 32'd4};

    reset = 1; start = 0; stall = 0; beq = 0; alu_zero = 0; j = 0;
    imem_we = 0; imem_addr = '0; imem_wdata = '0;
    @(posedge clk); #1;
    do_reset();

    load(8'd0, 32'h2401_0001);   // addiu $1,$0,1
    load(8'd1, 32'h2402_0002);   // addiu $2,$0,2
    load(8'd2, 32'hFFFF_FFFF);   // halt
    do_reset();
    @(negedge clk);
    chk("rst_pc",       -1, pc,                  32'h0);
    chk("rst_pc_plus4", -1, pc_plus4,            32'h4);
    chk("rst_valid",    -1, 32'(valid),          32'h0);
    chk("rst_halted",   -1, 32'(halted),         32'h0);
    chk("rst_fault",    -1, 32'(fault),          32'h0);
    chk("rst_retired",  -1, retired,             32'h0);
    chk("rst_instr",    -1, instr,               32'h2401_0001);
    chk("rst_opcode",   -1, 32'(opcode),         32'h09);
    chk("rst_funct",    -1, 32'(function_code),  32'h01);
    @(posedge clk); #1;
    run_steps(0, 4);

    // reload in HALT: beq offset -2 at word 2, halt at word 3
    load(8'd2, 32'h1000_FFFE);
    load(8'd3, 32'hFFFF_FFFF);
    @(negedge clk);
    chk("halt_reload_instr", -1, instr, 32'h1000_FFFE);
    @(posedge clk); #1;
    run_steps(5, 10);

    do_reset();
    load(8'd0,  32'h0800_0010);  // j 0x40
    load(8'd16, 32'h0800_0004);  // j 0x10 (imm field also 4, to expose beq priority)
    load(8'd4,  32'h2404_0004);  // addiu
    load(8'd5,  32'h0800_0100);  // j 0x400, out of range
    run_steps(11, 20);

    do_reset();
    @(negedge clk);
    chk("post_fault_pc",      -1, pc,          32'h0);
    chk("post_fault_fault",   -1, 32'(fault),  32'h0);
    chk("post_fault_retired", -1, retired,     32'h0);
    chk("mem_intact",         -1, instr,       32'h0800_0010);
    @(posedge clk); #1;

    // write port locked out in RUN, honoured in HALT, overridden by reset
    load(8'd0, 32'hFFFF_FFFF);
    start = 1; @(posedge clk); #1; start = 0;
    imem_we = 1; imem_addr = 8'd0; imem_wdata = 32'h1234_5678;
    @(negedge clk);
    chk("run_write_valid", -1, 32'(valid), 32'h0);
    @(posedge clk); #1;
    imem_we = 0;
    @(negedge clk);
    chk("run_write_halted",  -1, 32'(halted), 32'h1);
    chk("run_write_ignored", -1, instr,       32'hFFFF_FFFF);
    @(posedge clk); #1;
    load(8'd0, 32'h2403_0003);
    @(negedge clk);
    chk("halt_write_instr",  -1, instr,               32'h2403_0003);
    chk("halt_write_funct",  -1, 32'(function_code),  32'h03);
    @(posedge clk); #1;
    imem_we = 1; imem_addr = 8'd0; imem_wdata = 32'h1111_1111;
    do_reset();
    imem_we = 0;
    @(negedge clk);
    chk("reset_beats_write", -1, instr, 32'h2403_0003);
    chk("reset_halted",      -1, 32'(halted), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
